// File: rtl/keypad_event_ctrl.sv
// Keypad event sequencer: press/repeat/release events queued in a FWFT FIFO.
// Define KEYPAD_REPEAT_EN to build the auto-repeat state and timer.
module keypad_event_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_code,
    input  logic       key_ready,
    output logic       evt_valid,
    output logic [1:0] evt_kind,
    output logic [4:0] evt_code,
    input  logic       evt_ack,
    output logic       evt_overflow,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    localparam logic [1:0] K_PRESS   = 2'd0;
    localparam logic [1:0] K_RELEASE = 2'd2;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [1:0] K_REPEAT = 2'd1;
    localparam int unsigned DMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW = $clog2(DMAX) + 1;
    localparam logic [TW-1:0] DLY_RLD = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_RLD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [TW-1:0] tmr_q, tmr_d;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [4:0] code_q, code_d;
    logic       push;
    logic [6:0] push_data;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        push      = 1'b0;
        push_data = 7'd0;
`ifdef KEYPAD_REPEAT_EN
        tmr_d     = tmr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_ready) begin
                    push      = 1'b1;
                    push_data = {K_PRESS, key_code};
                    code_d    = key_code;
                    state_d   = HELD;
`ifdef KEYPAD_REPEAT_EN
                    tmr_d     = DLY_RLD;
`endif
                end
            end
`ifdef KEYPAD_REPEAT_EN
            HELD, REPEAT: begin
`else
            HELD: begin
`endif
                // Release wins over a repeat expiring on the same edge
                if (!key_ready || key_code != code_q) begin
                    push      = 1'b1;
                    push_data = {K_RELEASE, code_q};
                    state_d   = IDLE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (tmr_q == '0) begin
                    push      = 1'b1;
                    push_data = {K_REPEAT, code_q};
                    tmr_d     = PER_RLD;
                    state_d   = REPEAT;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= 5'd0;
`ifdef KEYPAD_REPEAT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
`ifdef KEYPAD_REPEAT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    logic [6:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        ovf_q;
    logic        empty, full, pop, wr_en;
    logic [6:0]  head;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && evt_ack;
    // On full, the slot being popped is the one written this edge
    assign wr_en = push && (!full || pop);
    assign head  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign evt_valid    = !empty;
    assign evt_kind     = empty ? 2'd0 : head[6:5];
    assign evt_code     = empty ? 5'd0 : head[4:0];
    assign evt_overflow = ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl (REPEAT_DELAY=8, REPEAT_PERIOD=4).
// Repeat expectations follow KEYPAD_REPEAT_EN.
module tb_keypad_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_code = 5'd0;
    logic       key_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_kind;
    logic [4:0] evt_code;
    logic       evt_ack = 1'b0;
    logic       evt_overflow;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef KEYPAD_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    keypad_event_ctrl #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .evt_valid   (evt_valid),
        .evt_kind    (evt_kind),
        .evt_code    (evt_code),
        .evt_ack     (evt_ack),
        .evt_overflow(evt_overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_evt(input string tag, input logic [1:0] k,
                           input logic [4:0] c);
        chk({tag, ".valid"}, {7'd0, evt_valid}, 8'd1);
        chk({tag, ".kind"}, {6'd0, evt_kind}, {6'd0, k});
        chk({tag, ".code"}, {3'd0, evt_code}, {3'd0, c});
    endtask

    task automatic exp_none(input string tag);
        chk({tag, ".valid"}, {7'd0, evt_valid}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst.valid", {7'd0, evt_valid}, 8'd0);
        chk("rst.kind", {6'd0, evt_kind}, 8'd0);
        chk("rst.code", {3'd0, evt_code}, 8'd0);
        chk("rst.ovf", {7'd0, evt_overflow}, 8'd0);
        chk("rst.busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;
        step();
        exp_none("idle");

        // short hold of 06, ack tied high
        evt_ack = 1'b1;
        key_code = 5'h06;
        key_ready = 1'b1;
        step();
        exp_evt("t1.press", 2'd0, 5'h06);
        chk("t1.busy", {7'd0, busy}, 8'd1);
        step();
        exp_none("t1.h1");
        step();
        exp_none("t1.h2");
        key_ready = 1'b0;
        step();
        exp_evt("t1.rel", 2'd2, 5'h06);
        chk("t1.idle", {7'd0, busy}, 8'd0);
        step();
        exp_none("t1.after");
        chk("t1.ovf", {7'd0, evt_overflow}, 8'd0);

        // 20-cycle hold of 11; release coincides with 4th repeat
        key_code = 5'h11;
        key_ready = 1'b1;
        step();
        exp_evt("t2.press", 2'd0, 5'h11);
        for (int i = 1; i < 20; i++) begin
            step();
            if (REP && (i == 8 || i == 12 || i == 16)) begin
                exp_evt($sformatf("t2.rep%0d", i), 2'd1, 5'h11);
            end else begin
                exp_none($sformatf("t2.n%0d", i));
            end
        end
        key_ready = 1'b0;
        step();
        exp_evt("t2.rel", 2'd2, 5'h11);
        step();
        exp_none("t2.after");

        // overflow: three taps with no ack
        evt_ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            key_code = 5'(k);
            key_ready = 1'b1;
            step();
            key_ready = 1'b0;
            step();
        end
        chk("t3.ovf", {7'd0, evt_overflow}, 8'd1);
        exp_evt("t3.h0", 2'd0, 5'h01);
        step();
        exp_evt("t3.stable", 2'd0, 5'h01);
        evt_ack = 1'b1;
        step();
        exp_evt("t3.h1", 2'd2, 5'h01);
        step();
        exp_evt("t3.h2", 2'd0, 5'h02);
        step();
        exp_evt("t3.h3", 2'd2, 5'h02);
        step();
        exp_none("t3.drained");
        chk("t3.ovf_sticky", {7'd0, evt_overflow}, 8'd1);

        // code change while ready stays high
        key_code = 5'h02;
        key_ready = 1'b1;
        step();
        exp_evt("t4.press02", 2'd0, 5'h02);
        key_code = 5'h0A;
        step();
        exp_evt("t4.rel02", 2'd2, 5'h02);
        step();
        exp_evt("t4.press0a", 2'd0, 5'h0A);
        key_ready = 1'b0;
        step();
        exp_evt("t4.rel0a", 2'd2, 5'h0A);
        step();
        exp_none("t4.after");

        // clear overflow, fill, then push and pop together while full
        rst_n = 1'b0;
        step();
        chk("t5.rst_ovf", {7'd0, evt_overflow}, 8'd0);
        rst_n = 1'b1;
        evt_ack = 1'b0;
        for (int k = 4; k <= 5; k++) begin
            key_code = 5'(k);
            key_ready = 1'b1;
            step();
            key_ready = 1'b0;
            step();
        end
        exp_evt("t5.full_head", 2'd0, 5'h04);
        key_code = 5'h07;
        key_ready = 1'b1;
        evt_ack = 1'b1;
        step();
        exp_evt("t5.h1", 2'd2, 5'h04);
        chk("t5.ovf1", {7'd0, evt_overflow}, 8'd0);
        key_ready = 1'b0;
        step();
        exp_evt("t5.h2", 2'd0, 5'h05);
        chk("t5.ovf2", {7'd0, evt_overflow}, 8'd0);
        step();
        exp_evt("t5.h3", 2'd2, 5'h05);
        step();
        exp_evt("t5.h4", 2'd0, 5'h07);
        step();
        exp_evt("t5.h5", 2'd2, 5'h07);
        step();
        exp_none("t5.drained");

        // reset mid-repeat with entries queued, key still held
        evt_ack = 1'b0;
        key_code = 5'h0C;
        key_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
        end
        exp_evt("t6.head", 2'd0, 5'h0C);
        chk("t6.busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        step();
        exp_none("t6.rst");
        chk("t6.rst_busy", {7'd0, busy}, 8'd0);
        chk("t6.rst_kind", {6'd0, evt_kind}, 8'd0);
        rst_n = 1'b1;
        step();
        exp_evt("t6.repress", 2'd0, 5'h0C);
        key_ready = 1'b0;
        evt_ack = 1'b1;
        step();
        exp_evt("t6.rel", 2'd2, 5'h0C);
        step();
        exp_none("t6.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
